// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic PORT_S = 1'b0;
  localparam logic PORT_H = 1'b1;

  localparam int unsigned RD_LAT_DEF     = 1;
  localparam int unsigned STARVE_LIM_DEF = 4;
  localparam int unsigned STREAK_W       = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the memory.
interface dm_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);

  logic              s_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  // Arbiter side.
  modport slave (
    input  s_req, s_we, s_addr, s_wdata,
    input  h_req, h_we, h_addr, h_wdata,
    input  mem_rdata,
    output s_gnt, s_rvalid, s_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output mem_addr, mem_we, mem_wdata,
    output busy, owner
  );

  // Requesters and memory side.
  modport master (
    output s_req, s_we, s_addr, s_wdata,
    output h_req, h_we, h_addr, h_wdata,
    output mem_rdata,
    input  s_gnt, s_rvalid, s_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  mem_addr, mem_we, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational winner picker: S has priority until its streak reaches the limit.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                i_s_req,
  input  logic                i_h_req,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_valid,
  output logic                o_winner
);

  logic w_starved;

  always_comb begin
    w_starved = (i_streak == STREAK_W'(STARVE_LIM));
    o_valid   = i_s_req | i_h_req;
    o_winner  = PORT_S;
    if (i_h_req && (!i_s_req || w_starved)) begin
      o_winner = PORT_H;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory: latches the winning request,
// issues it for one cycle and returns read data after the memory latency.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  // Index of the final WAIT cycle; unused when RD_LAT is zero.
  localparam logic [1:0] LastWait = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_s_rdata;
  logic [DATA_W-1:0]   r_h_rdata;

  logic w_valid;
  logic w_winner;
  logic w_latch;
  logic w_capture;

  dm_arb_pick #(
    .STARVE_LIM(STARVE_LIM)
  ) u_pick (
    .i_s_req (bus.s_req),
    .i_h_req (bus.h_req),
    .i_streak(r_streak),
    .o_valid (w_valid),
    .o_winner(w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_valid) w_state_nxt = StIssue;
      end
      StIssue: begin
        if (r_we)             w_state_nxt = StIdle;
        else if (RD_LAT == 0) w_state_nxt = StResp;
        else                  w_state_nxt = StWait;
      end
      StWait: begin
        if (r_cnt == LastWait) w_state_nxt = StResp;
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_latch   = (r_state == StIdle) && w_valid;
    // Read data is sampled on the last edge before RESP.
    w_capture = ((r_state == StIssue) && !r_we && (RD_LAT == 0)) ||
                ((r_state == StWait) && (r_cnt == LastWait));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_owner   <= PORT_S;
      r_streak  <= '0;
      r_cnt     <= '0;
      r_s_rdata <= '0;
      r_h_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_owner <= w_winner;
        if (w_winner == PORT_H) begin
          r_we     <= bus.h_we;
          r_addr   <= bus.h_addr;
          r_wdata  <= bus.h_wdata;
          r_streak <= '0;
        end else begin
          r_we    <= bus.s_we;
          r_addr  <= bus.s_addr;
          r_wdata <= bus.s_wdata;
          if (!bus.h_req) begin
            r_streak <= '0;
          end else if (r_streak != STREAK_W'(STARVE_LIM)) begin
            r_streak <= r_streak + 1'b1;
          end
        end
      end

      if (r_state == StWait) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;

      if (w_capture) begin
        if (r_owner == PORT_H) r_h_rdata <= bus.mem_rdata;
        else                   r_s_rdata <= bus.mem_rdata;
      end
    end
  end

  // Strobes decode from the async-reset state, so mem_we falls the moment reset rises.
  always_comb begin
    bus.s_gnt     = (r_state == StIssue) && (r_owner == PORT_S);
    bus.h_gnt     = (r_state == StIssue) && (r_owner == PORT_H);
    bus.mem_we    = (r_state == StIssue) && r_we;
    bus.s_rvalid  = (r_state == StResp) && (r_owner == PORT_S);
    bus.h_rvalid  = (r_state == StResp) && (r_owner == PORT_H);
    bus.busy      = (r_state != StIdle);
    bus.owner     = r_owner;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.s_rdata   = r_s_rdata;
    bus.h_rdata   = r_h_rdata;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Four arbiter lanes with RD_LAT 0..3, each with its own memory model; a transaction-level
// model predicts grants, read data, busy and owner cycle by cycle for the active lane.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int NL  = 4;
  localparam int LIM = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req    [NL][2];
  logic       we     [NL][2];
  logic [6:0] addr   [NL][2];
  logic [7:0] wdata  [NL][2];
  logic       gnt    [NL][2];
  logic       rvld   [NL][2];
  logic [7:0] rdata  [NL][2];
  logic       m_we   [NL];
  logic [6:0] m_addr [NL];
  logic [7:0] m_wdata[NL];
  logic       busy   [NL];
  logic       owner  [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    dm_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();
    logic [7:0] mem [128] = '{default: 8'h00};

    dm_arbiter #(
      .ADDR_W(7), .DATA_W(8), .RD_LAT(g), .STARVE_LIM(LIM)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    assign bus.s_req   = req[g][0];
    assign bus.s_we    = we[g][0];
    assign bus.s_addr  = addr[g][0];
    assign bus.s_wdata = wdata[g][0];
    assign bus.h_req   = req[g][1];
    assign bus.h_we    = we[g][1];
    assign bus.h_addr  = addr[g][1];
    assign bus.h_wdata = wdata[g][1];
    assign gnt[g][0]   = bus.s_gnt;
    assign gnt[g][1]   = bus.h_gnt;
    assign rvld[g][0]  = bus.s_rvalid;
    assign rvld[g][1]  = bus.h_rvalid;
    assign rdata[g][0] = bus.s_rdata;
    assign rdata[g][1] = bus.h_rdata;
    assign m_we[g]     = bus.mem_we;
    assign m_addr[g]   = bus.mem_addr;
    assign m_wdata[g]  = bus.mem_wdata;
    assign busy[g]     = bus.busy;
    assign owner[g]    = bus.owner;

    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    if (g == 0) begin : g_comb
      assign bus.mem_rdata = mem[bus.mem_addr];
    end else begin : g_pipe
      logic [7:0] pl [g];
      always @(posedge clk) begin
        pl[0] <= mem[bus.mem_addr];
        for (int i = 1; i < g; i++) pl[i] <= pl[i-1];
      end
      assign bus.mem_rdata = pl[g-1];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model state for the active lane k; cyc counts negedges since reset release.
  int         k;
  int         cyc;
  int         next_pick, g_cyc, r_cyc, busy_hi, streak;
  bit         g_port, g_we, r_port, m_own, rnd_mode;
  logic [6:0] g_addr, m_last_addr;
  logic [7:0] g_wdata, r_data, m_last_wdata;
  logic [7:0] m_rd   [2];
  bit         keep   [2];
  logic [7:0] shadow [NL][128];
  int         gnt_log[$];
  int         exp10 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int         exp5  [5]  = '{0, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h, want %0h (lane %0d cycle %0d)", tag, obs, exp, k, cyc);
    end
  endtask

  task automatic model_clear();
    cyc          = 0;
    next_pick    = 0;
    g_cyc        = -10;
    r_cyc        = -10;
    busy_hi      = -10;
    g_we         = 1'b0;
    g_port       = 1'b0;
    r_port       = 1'b0;
    streak       = 0;
    m_rd[0]      = 8'h00;
    m_rd[1]      = 8'h00;
    m_own        = 1'b0;
    m_last_addr  = 7'h00;
    m_last_wdata = 8'h00;
  endtask

  function automatic bit h_wins(input bit s, input bit h, input int st);
    return h && (!s || st == LIM);
  endfunction

  task automatic drive(input int p, input bit w, input logic [6:0] a, input logic [7:0] d);
    req[k][p]   = 1'b1;
    we[k][p]    = w;
    addr[k][p]  = a;
    wdata[k][p] = d;
  endtask

  task automatic drive_rand(input int p);
    drive(p, 1'($urandom_range(1, 0)), 7'($urandom_range(127, 0)), 8'($urandom_range(255, 0)));
  endtask

  // Decide what the edge ending the current cycle does, advance one cycle, check outputs.
  task automatic tick();
    bit w;
    if (g_we && cyc == g_cyc) shadow[k][g_addr] = g_wdata;
    if (cyc >= next_pick && (req[k][0] || req[k][1])) begin
      w = h_wins(req[k][0], req[k][1], streak);
      if (w || !req[k][1]) streak = 0;
      else if (streak < LIM) streak++;
      g_cyc   = cyc + 1;
      g_port  = w;
      g_we    = we[k][w];
      g_addr  = addr[k][w];
      g_wdata = wdata[k][w];
      if (g_we) begin
        next_pick = cyc + 2;
        busy_hi   = cyc + 1;
      end else begin
        r_cyc     = cyc + 2 + k;
        r_port    = w;
        r_data    = shadow[k][g_addr];
        next_pick = cyc + 3 + k;
        busy_hi   = r_cyc;
      end
    end
    @(negedge clk);
    cyc++;
    if (cyc == g_cyc) begin
      m_own        = g_port;
      m_last_addr  = g_addr;
      m_last_wdata = g_wdata;
    end
    if (cyc == r_cyc) m_rd[r_port] = r_data;
    chk("s_gnt", 32'(gnt[k][0]), 32'(cyc == g_cyc && !g_port));
    chk("h_gnt", 32'(gnt[k][1]), 32'(cyc == g_cyc && g_port));
    chk("mem_we", 32'(m_we[k]), 32'(cyc == g_cyc && g_we));
    chk("mem_addr", 32'(m_addr[k]), 32'(m_last_addr));
    chk("mem_wdata", 32'(m_wdata[k]), 32'(m_last_wdata));
    chk("s_rvalid", 32'(rvld[k][0]), 32'(cyc == r_cyc && !r_port));
    chk("h_rvalid", 32'(rvld[k][1]), 32'(cyc == r_cyc && r_port));
    chk("s_rdata", 32'(rdata[k][0]), 32'(m_rd[0]));
    chk("h_rdata", 32'(rdata[k][1]), 32'(m_rd[1]));
    chk("busy", 32'(busy[k]), 32'(cyc >= g_cyc && cyc <= busy_hi));
    chk("owner", 32'(owner[k]), 32'(m_own));
    if (gnt[k][0]) gnt_log.push_back(0);
    if (gnt[k][1]) gnt_log.push_back(1);
    if (cyc == g_cyc) begin
      if (rnd_mode) begin
        if ($urandom_range(1, 0) == 1) drive_rand(int'(g_port));
        else req[k][g_port] = 1'b0;
      end else if (!keep[g_port]) begin
        req[k][g_port] = 1'b0;
      end
    end
    if (rnd_mode) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[k][p] && $urandom_range(2, 0) == 0) drive_rand(p);
      end
    end
  endtask

  // One access from idle; checks cycles from the sampling edge to gnt (write) or rvalid (read).
  task automatic access(input int p, input bit w, input logic [6:0] a, input logic [7:0] d,
                        input int lat);
    int  s0;
    bit  seen;
    drive(p, w, a, d);
    s0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (w ? gnt[k][p] : rvld[k][p]) seen = 1'b1;
    end
    chk(w ? "wr_latency" : "rd_latency", seen ? 32'(cyc - s0) : 32'hFFFF_FFFF, 32'(lat));
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_we"}, 32'(m_we[k]), 32'd0);
    chk({tag, "_s_gnt"}, 32'(gnt[k][0]), 32'd0);
    chk({tag, "_h_gnt"}, 32'(gnt[k][1]), 32'd0);
    chk({tag, "_s_rvalid"}, 32'(rvld[k][0]), 32'd0);
    chk({tag, "_h_rvalid"}, 32'(rvld[k][1]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
    chk({tag, "_s_rdata"}, 32'(rdata[k][0]), 32'd0);
    chk({tag, "_h_rdata"}, 32'(rdata[k][1]), 32'd0);
    chk({tag, "_owner"}, 32'(owner[k]), 32'd0);
    chk({tag, "_mem_addr"}, 32'(m_addr[k]), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(m_wdata[k]), 32'd0);
  endtask

  // Called at a negedge: raise reset mid-cycle, check the immediate effect, release later.
  task automatic reset_mid(input string tag);
    #3 reset = 1'b1;
    #1 check_zero(tag);
    @(negedge clk);
    check_zero({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic run_grants(input int n);
    for (int i = 0; i < 80 && gnt_log.size() < n; i++) tick();
    if (gnt_log.size() < n) chk("grant_timeout", 32'(gnt_log.size()), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < NL; l++) begin
      for (int p = 0; p < 2; p++) begin
        req[l][p]   = 1'b0;
        we[l][p]    = 1'b0;
        addr[l][p]  = 7'h00;
        wdata[l][p] = 8'h00;
      end
      for (int i = 0; i < 128; i++) shadow[l][i] = 8'h00;
    end
    keep[0]  = 1'b0;
    keep[1]  = 1'b0;
    rnd_mode = 1'b0;

    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      k = l;
      check_zero("rst_init");
    end
    reset = 1'b0;
    k     = 1;
    model_clear();

    // S write 0x05=0xA5, H reads it back.
    access(0, 1'b1, 7'h05, 8'hA5, 1);
    access(1, 1'b0, 7'h05, 8'h00, 3);
    chk("h_rdata_a5", 32'(rdata[1][1]), 32'h0000_00A5);
    chk("s_rdata_unchanged", 32'(rdata[1][0]), 32'h0000_0000);

    // Boundary addresses must not alias.
    access(0, 1'b1, 7'h7F, 8'h3C, 1);
    access(0, 1'b1, 7'h00, 8'hC3, 1);
    access(1, 1'b0, 7'h7F, 8'h00, 3);
    access(0, 1'b0, 7'h00, 8'h00, 3);
    chk("rd_7f", 32'(rdata[1][1]), 32'h0000_003C);
    chk("rd_00", 32'(rdata[1][0]), 32'h0000_00C3);

    // Reset while a write is in ISSUE: the write never lands.
    drive(0, 1'b1, 7'h33, 8'h99);
    tick();
    reset_mid("rst_issue");
    access(1, 1'b0, 7'h33, 8'h00, 3);
    chk("abandoned_write", 32'(rdata[1][1]), 32'h0000_0000);

    // Contention with both ports re-requesting.
    keep[0] = 1'b1;
    keep[1] = 1'b1;
    drive(0, 1'b1, 7'h01, 8'h11);
    drive(1, 1'b1, 7'h02, 8'h22);
    gnt_log.delete();
    run_grants(10);
    for (int i = 0; i < 10; i++)
      chk("grant_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(exp10[i]));
    keep[1]    = 1'b0;
    req[1][1]  = 1'b0;
    gnt_log.delete();
    run_grants(6);
    for (int i = 0; i < 6; i++)
      chk("s_only", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'd0);
    keep[1] = 1'b1;
    drive(1, 1'b1, 7'h02, 8'h22);
    gnt_log.delete();
    run_grants(5);
    for (int i = 0; i < 5; i++)
      chk("streak_cleared", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF,
          32'(exp5[i]));
    keep[0] = 1'b0;
    keep[1] = 1'b0;
    repeat (10) tick();

    // Random traffic on lane 1.
    rnd_mode = 1'b1;
    repeat (300) tick();
    rnd_mode = 1'b0;
    repeat (30) tick();

    // RD_LAT=2: reset during the first WAIT cycle with s_req kept high.
    k = 2;
    model_clear();
    access(0, 1'b1, 7'h10, 8'h77, 1);
    keep[0] = 1'b1;
    drive(0, 1'b0, 7'h10, 8'h00);
    tick();
    tick();
    reset_mid("rst_wait");
    keep[0] = 1'b0;
    tick();
    chk("gnt_after_rst", 32'(gnt[2][0]), 32'd1);
    repeat (6) tick();
    chk("rd_after_rst", 32'(rdata[2][0]), 32'h0000_0077);

    // RD_LAT variants 0 and 3.
    k = 0;
    model_clear();
    access(0, 1'b1, 7'h22, 8'h5A, 1);
    access(1, 1'b0, 7'h22, 8'h00, 2);
    chk("lat0_data", 32'(rdata[0][1]), 32'h0000_005A);
    k = 3;
    model_clear();
    access(0, 1'b1, 7'h22, 8'h5A, 1);
    access(1, 1'b0, 7'h22, 8'h00, 5);
    chk("lat3_data", 32'(rdata[3][1]), 32'h0000_005A);
    rnd_mode = 1'b1;
    repeat (200) tick();
    rnd_mode = 1'b0;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
